fifo_unpacker: RTL and testbench

Read-side drain stage that sits directly downstream of the team's synchronous FIFO. It pops FIFO_WIDTH-bit words and re-emits them as a narrower OUT_WIDTH-bit valid/ready stream, least-significant lane first. It hides the FIFO's one-cycle read latency with a two-word buffer and in-flight credit tracking, so the output sustains one lane per cycle.

---
 rtl/fifo_unpacker.sv | 86 ++++++++
 tb/tb_fifo_unpacker.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_unpacker.sv
// fifo_unpacker
//   Drains a synchronous FIFO (one-cycle read latency) and re-emits each
//   FIFO_WIDTH-bit word as RATIO lanes of OUT_WIDTH bits on a valid/ready
//   stream, lane 0 (LSBs) first. A two-entry word buffer plus an in-flight
//   flag lets reads be issued ahead, so one lane leaves per cycle.
// Ports
//   clk, rst_n      : clock, synchronous active-low reset
//   fifo_empty      : FIFO empty flag (in)
//   fifo_read_en    : FIFO pop strobe (out)
//   fifo_read_data  : FIFO data, valid the cycle after fifo_read_en (in)
//   m_valid/m_data  : output lane stream (out)
//   m_last          : last lane of the current word (out)
//   m_ready         : downstream accept (in)
module fifo_unpacker #(
  parameter int FIFO_WIDTH = 32,
  parameter int OUT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  output logic                  fifo_read_en,
  input  logic [FIFO_WIDTH-1:0] fifo_read_data,
  output logic                  m_valid,
  output logic [OUT_WIDTH-1:0]  m_data,
  output logic                  m_last,
  input  logic                  m_ready
);
  localparam int RATIO = FIFO_WIDTH / OUT_WIDTH;
  localparam int LW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [LW-1:0] LAST_LANE = LW'(RATIO - 1);

  logic [FIFO_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic [1:0]            occ_q, occ_d;
  logic [LW-1:0]         lane_q, lane_d;
  logic                  infl_q, infl_d;

  // Lane view of the head word.
  logic [RATIO-1:0][OUT_WIDTH-1:0] head_lanes;
  assign head_lanes = head_q;

  logic       last, xfer, pop;
  logic [2:0] credit;

  always_comb begin
    last    = (lane_q == LAST_LANE);
    m_valid = (occ_q != 2'd0);
    m_data  = head_lanes[lane_q];
    m_last  = m_valid && last;
    xfer    = m_valid && m_ready;
    pop     = xfer && last;
    // Words held or arriving after this cycle; pop implies occ>=1, no underflow.
    credit  = {1'b0, occ_q} + {2'b0, infl_q} - {2'b0, pop};
    fifo_read_en = rst_n && !fifo_empty && (credit < 3'd2);

    occ_d  = credit[1:0];
    infl_d = fifo_read_en;

    lane_d = lane_q;
    if (xfer) lane_d = last ? '0 : lane_q + LW'(1);

    head_d = head_q;
    tail_d = tail_q;
    if (pop) head_d = tail_q;
    // Arriving word lands in the first entry still free after any pop.
    if (infl_q) begin
      if ((occ_q - {1'b0, pop}) == 2'd0) head_d = fifo_read_data;
      else                               tail_d = fifo_read_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
      lane_q <= '0;
      infl_q <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
      lane_q <= lane_d;
      infl_q <= infl_d;
    end
  end
endmodule

// File: tb/tb_fifo_unpacker.sv
// Bench for fifo_unpacker: a 32->8 instance and a 32->32 pass-through
// instance, each fed by a queue-based FIFO model; an expected-lane queue
// is built from the words the FIFO hands out.
module tb_fifo_unpacker;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        a_empty, a_ren, a_mv, a_ml, a_mr;
  logic [31:0] a_rdata;
  logic [7:0]  a_md;
  logic        b_empty, b_ren, b_mv, b_ml, b_mr;
  logic [31:0] b_rdata, b_md;

  fifo_unpacker #(.FIFO_WIDTH(32), .OUT_WIDTH(8)) u_a (
    .clk(clk), .rst_n(rst_n), .fifo_empty(a_empty), .fifo_read_en(a_ren),
    .fifo_read_data(a_rdata), .m_valid(a_mv), .m_data(a_md), .m_last(a_ml),
    .m_ready(a_mr));

  fifo_unpacker #(.FIFO_WIDTH(32), .OUT_WIDTH(32)) u_b (
    .clk(clk), .rst_n(rst_n), .fifo_empty(b_empty), .fifo_read_en(b_ren),
    .fifo_read_data(b_rdata), .m_valid(b_mv), .m_data(b_md), .m_last(b_ml),
    .m_ready(b_mr));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // FIFO contents and expected output lanes {last, data}
  logic [31:0] qa[$], qb[$];
  logic [8:0]  expa[$];
  logic [32:0] expb[$];
  logic        pend_a = 0, pend_b = 0;
  logic [31:0] pend_wa, pend_wb;
  logic        ren_a_s = 0, ren_b_s = 0;
  int ren_a_cnt = 0, ren_b_cnt = 0, xfer_a = 0, xfer_b = 0, last_a = 0;
  logic        hold_a = 0, hold_b = 0;
  logic [7:0]  hold_ad;
  logic [31:0] hold_bd;

  // FIFO model: pops on a strobe sampled before the edge, data next cycle.
  // A word read out becomes expected output one cycle later unless reset hits.
  always @(posedge clk) begin
    if (!rst_n) begin
      expa.delete(); expb.delete();
    end else begin
      if (pend_a) for (int l = 0; l < 4; l++) expa.push_back({1'(l == 3), pend_wa[l*8 +: 8]});
      if (pend_b) expb.push_back({1'b1, pend_wb});
    end
    pend_a = 0;
    if (ren_a_s && qa.size() > 0) begin
      pend_wa = qa.pop_front(); a_rdata <= pend_wa; pend_a = rst_n;
    end else a_rdata <= $urandom;
    pend_b = 0;
    if (ren_b_s && qb.size() > 0) begin
      pend_wb = qb.pop_front(); b_rdata <= pend_wb; pend_b = rst_n;
    end else b_rdata <= $urandom;
    a_empty <= (qa.size() == 0);
    b_empty <= (qb.size() == 0);
  end

  // Monitor: lane order/content, hold stability, no read while empty.
  always @(negedge clk) begin
    logic [8:0]  ea;
    logic [32:0] eb;
    ren_a_s = a_ren;
    ren_b_s = b_ren;
    if (a_ren) begin chk("a_ren_when_empty", a_empty, 0); ren_a_cnt++; end
    if (b_ren) begin chk("b_ren_when_empty", b_empty, 0); ren_b_cnt++; end
    if (rst_n && hold_a) begin
      chk("a_hold_valid", a_mv, 1); chk("a_hold_data", a_md, hold_ad);
    end
    if (rst_n && hold_b) begin
      chk("b_hold_valid", b_mv, 1); chk("b_hold_data", b_md, hold_bd);
    end
    hold_a = rst_n && a_mv && !a_mr; hold_ad = a_md;
    hold_b = rst_n && b_mv && !b_mr; hold_bd = b_md;
    if (rst_n && a_mv && a_mr) begin
      chk("a_lane_expected", expa.size() != 0, 1);
      if (expa.size() != 0) begin
        ea = expa.pop_front();
        chk("a_lane_data", a_md, ea[7:0]);
        chk("a_lane_last", a_ml, ea[8]);
      end
      xfer_a++;
      if (a_ml) last_a++;
    end
    if (rst_n && b_mv && b_mr) begin
      chk("b_word_expected", expb.size() != 0, 1);
      if (expb.size() != 0) begin
        eb = expb.pop_front();
        chk("b_word_data", b_md, eb[31:0]);
        chk("b_word_last", b_ml, eb[32]);
      end
      xfer_b++;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clr_cnt();
    ren_a_cnt = 0; ren_b_cnt = 0; xfer_a = 0; xfer_b = 0; last_a = 0;
  endtask

  initial begin
    logic [7:0]  sw[4];
    logic [31:0] w, w0, nw0, nw1;
    logic [9:0]  ren_pat, mv_pat, ml_pat;
    int bub;
    sw = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
    rst_n = 0; a_mr = 1; b_mr = 1; a_empty = 0; b_empty = 1;
    qa.push_back(32'hA1B2C3D4);

    // reset with FIFO non-empty
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_ren", a_ren, 0); chk("rst_mvalid", a_mv, 0);
      chk("rst_mdata", a_md, 0); chk("rst_mlast", a_ml, 0);
      chk("rst_b_mvalid", b_mv, 0);
    end
    tick(); rst_n = 1;

    // single word
    @(negedge clk); chk("single_ren_T", a_ren, 1); chk("single_mv_T", a_mv, 0);
    @(negedge clk); chk("single_ren_T1", a_ren, 0); chk("single_mv_T1", a_mv, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("single_mv", a_mv, 1); chk("single_md", a_md, sw[i]);
      chk("single_ml", a_ml, 1'(i == 3));
    end
    @(negedge clk); chk("single_mv_drop", a_mv, 0);
    #1 chk("single_ren_cnt", ren_a_cnt, 1);

    // streaming 8 words
    tick(); clr_cnt();
    for (int i = 0; i < 8; i++) qa.push_back(32'(i) * 32'h01010101);
    for (int k = 0; k < 20; k++) begin @(negedge clk); if (a_mv) break; end
    chk("stream_start", a_mv, 1);
    bub = 0;
    for (int i = 0; i < 32; i++) begin if (!a_mv) bub++; @(negedge clk); end
    chk("stream_nobubble", bub, 0);
    chk("stream_end_mv", a_mv, 0);
    #1;
    chk("stream_ren_cnt", ren_a_cnt, 8); chk("stream_xfer", xfer_a, 32);
    chk("stream_lasts", last_a, 8); chk("stream_drained", expa.size(), 0);

    // backpressure
    tick(); clr_cnt(); a_mr = 0;
    for (int i = 0; i < 5; i++) begin
      w = $urandom; if (i == 0) w0 = w; qa.push_back(w);
    end
    repeat (10) @(posedge clk);
    @(negedge clk); #1;
    chk("bp_ren_cnt", ren_a_cnt, 2); chk("bp_mv", a_mv, 1);
    chk("bp_md_frozen", a_md, w0[7:0]); chk("bp_xfer", xfer_a, 0);
    tick(); a_mr = 1;
    for (int k = 0; k < 60; k++) begin @(negedge clk); #1; if (xfer_a == 20) break; end
    chk("bp_xfer_all", xfer_a, 20); chk("bp_ren_all", ren_a_cnt, 5);
    chk("bp_drained", expa.size(), 0);

    // pass-through, full rate
    tick(); clr_cnt();
    for (int i = 0; i < 6; i++) qb.push_back($urandom);
    for (int k = 0; k < 10; k++) begin @(negedge clk); if (b_ren) break; end
    chk("r1_ren_start", b_ren, 1);
    for (int i = 0; i < 10; i++) begin
      ren_pat[i] = b_ren; mv_pat[i] = b_mv; ml_pat[i] = b_ml; @(negedge clk);
    end
    chk("r1_ren_pat", ren_pat, 10'h03F); chk("r1_mv_pat", mv_pat, 10'h0FC);
    chk("r1_ml_pat", ml_pat, 10'h0FC);
    #1 chk("r1_xfer", xfer_b, 6); chk("r1_drained", expb.size(), 0);

    // reset mid-operation, during lane 2 of word 1
    tick(); clr_cnt();
    for (int i = 0; i < 4; i++) qa.push_back($urandom);
    for (int k = 0; k < 60; k++) begin @(negedge clk); #1; if (xfer_a == 7) break; end
    chk("mid_reach_lane", xfer_a, 7);
    rst_n = 0; qa.delete();
    @(negedge clk); chk("mid_rst_mv", a_mv, 0); chk("mid_rst_ren", a_ren, 0);
    @(negedge clk); chk("mid_rst_mv2", a_mv, 0);
    tick(); rst_n = 1; clr_cnt();
    nw0 = $urandom; nw1 = $urandom; qa.push_back(nw0); qa.push_back(nw1);
    for (int k = 0; k < 20; k++) begin @(negedge clk); if (a_mv) break; end
    chk("mid_restart_mv", a_mv, 1); chk("mid_restart_lane0", a_md, nw0[7:0]);
    for (int k = 0; k < 40; k++) begin @(negedge clk); #1; if (xfer_a == 8) break; end
    repeat (4) @(negedge clk);
    #1;
    chk("mid_xfer", xfer_a, 8); chk("mid_drained", expa.size(), 0);
    chk("mid_idle_mv", a_mv, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end
endmodule
